fifo_prog_wr_ctrl: RTL and testbench



---
 rtl/fifo_prog_wr_ctrl_pkg.sv | 33 +++
 rtl/fifo_prog_wr_ctrl_if.sv | 24 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/fifo_prog_wr_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fifo_prog_wr_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_prog_wr_ctrl_pkg.sv
// Shared types and constants for the FIFO program/write controller.
//   state_e   : controller sequence RST_FIFO -> PROG0..PROG3 -> SETTLE -> RUN
//   prog_word : data word driven on FIFO_D for each of the offset programming steps
package fifo_prog_wr_ctrl_pkg;
  localparam int FIFO_DW    = 9;
  localparam int OFF_W      = 9;
  localparam int PROG_WORDS = 4;
  localparam int PIDX_W     = $clog2(PROG_WORDS);

  typedef enum logic [2:0] {
    RST_FIFO,
    PROG0,
    PROG1,
    PROG2,
    PROG3,
    SETTLE,
    RUN
  } state_e;

  // Offsets go in as low byte then MSB, empty pair first, then full pair.
  function automatic logic [FIFO_DW-1:0] prog_word(input logic [PIDX_W-1:0] idx,
                                                   input logic [OFF_W-1:0]  e,
                                                   input logic [OFF_W-1:0]  f);
    logic [FIFO_DW-1:0] w;
    case (idx)
      2'd0:    w = {1'b0, e[7:0]};
      2'd1:    w = {8'b0, e[8]};
      2'd2:    w = {1'b0, f[7:0]};
      default: w = {8'b0, f[8]};
    endcase
    return w;
  endfunction
endpackage

// File: rtl/fifo_prog_wr_ctrl_if.sv
// Requester handshake plus FIFO-facing bus of the controller.
//   master : requester/FIFO side (drives REQx, Dx, FIFO_FF, FIFO_PAF)
//   slave  : controller side (drives ACKx, FIFO_RS, FIFO_D, FIFO_WEN1, FIFO_WEN2)
interface fifo_prog_wr_ctrl_if;
  import fifo_prog_wr_ctrl_pkg::*;

  logic               REQ0, REQ1;
  logic [FIFO_DW-1:0] D0, D1;
  logic               ACK0, ACK1;
  logic               FIFO_FF, FIFO_PAF;
  logic               FIFO_RS;
  logic [FIFO_DW-1:0] FIFO_D;
  logic               FIFO_WEN1, FIFO_WEN2;

  modport master (
    output REQ0, REQ1, D0, D1, FIFO_FF, FIFO_PAF,
    input  ACK0, ACK1, FIFO_RS, FIFO_D, FIFO_WEN1, FIFO_WEN2
  );

  modport slave (
    input  REQ0, REQ1, D0, D1, FIFO_FF, FIFO_PAF,
    output ACK0, ACK1, FIFO_RS, FIFO_D, FIFO_WEN1, FIFO_WEN2
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset (pointer -> requester 0)
//   elig[1:0]  : requester eligibility
//   stall      : blocks all grants
//   advance    : grants only allowed when high
//   gnt[1:0]   : combinational one-hot grant; the pointer flips to the other
//                requester on every grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  input  logic       stall,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (advance && !stall && (|elig)) begin
      if (elig[ptr_q]) gnt[ptr_q]  = 1'b1;
      else             gnt[~ptr_q] = 1'b1;
    end
    // granting 0 prefers 1 next time and vice versa
    if (|gnt) ptr_d = gnt[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fifo_prog_wr_ctrl.sv
// Controller in front of a 9-bit x 256 FIFO: resets the FIFO, programs the
// almost-empty/almost-full offsets via four WEN2 writes, then arbitrates two
// write requesters round-robin onto the FIFO write port.
//   CLK, RS_N              : clock (also FIFO WCLK), sync active-low reset
//   CFG_EMPTY_OFF/FULL_OFF : offsets, snapshotted on the last FIFO reset cycle
//   CFG_START              : in RUN, flush and reprogram the FIFO
//   bus (slave)            : requester handshake and FIFO pins, all registered
//   CFG_DONE               : high in RUN
//   WR_COUNT               : words issued since reset / CFG_START
// Build option: FIFO_PROG_WR_CTRL_PAF_THROTTLE_EN also stalls writes on FIFO_PAF.
module fifo_prog_wr_ctrl
  import fifo_prog_wr_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RS_N,
  input  logic [OFF_W-1:0]     CFG_EMPTY_OFF,
  input  logic [OFF_W-1:0]     CFG_FULL_OFF,
  input  logic                 CFG_START,
  fifo_prog_wr_ctrl_if.slave   bus,
  output logic                 CFG_DONE,
  output logic [CNT_W-1:0]     WR_COUNT
);
  localparam int RCW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

  state_e             state_q, state_d;
  logic [RCW-1:0]     rcnt_q, rcnt_d;
  logic [OFF_W-1:0]   empty_q, empty_d;
  logic [OFF_W-1:0]   full_q, full_d;
  logic               rs_q, rs_d;
  logic               wen1_q, wen1_d;
  logic               wen2_q, wen2_d;
  logic [FIFO_DW-1:0] fd_q, fd_d;
  logic [1:0]         ack_q, ack_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]         elig, gnt;
  logic               stall, advance;

  // A requester whose ACK is showing this cycle still holds the old word.
  assign elig    = {bus.REQ1 && !ack_q[1], bus.REQ0 && !ack_q[0]};
  assign advance = (state_q == RUN) && !CFG_START;

`ifdef FIFO_PROG_WR_CTRL_PAF_THROTTLE_EN
  assign stall = bus.FIFO_FF || bus.FIFO_PAF;
`else
  logic unused_paf;
  assign unused_paf = bus.FIFO_PAF;
  assign stall      = bus.FIFO_FF;
`endif

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst_n   (RS_N),
    .elig    (elig),
    .stall   (stall),
    .advance (advance),
    .gnt     (gnt)
  );

  // Outputs are computed for the state being entered so every FIFO pin is a flop.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    empty_d = empty_q;
    full_d  = full_q;
    rs_d    = 1'b0;
    wen1_d  = 1'b1;
    wen2_d  = 1'b1;
    fd_d    = fd_q;
    ack_d   = 2'b00;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      RST_FIFO: begin
        if (rcnt_q <= RCW'(1)) begin
          // last reset cycle: capture offsets and issue the first program word
          state_d = PROG0;
          empty_d = CFG_EMPTY_OFF;
          full_d  = CFG_FULL_OFF;
          wen2_d  = 1'b0;
          fd_d    = prog_word(2'd0, CFG_EMPTY_OFF, CFG_FULL_OFF);
        end else begin
          rcnt_d = rcnt_q - RCW'(1);
          rs_d   = 1'b1;
        end
      end
      PROG0: begin
        state_d = PROG1;
        wen2_d  = 1'b0;
        fd_d    = prog_word(2'd1, empty_q, full_q);
      end
      PROG1: begin
        state_d = PROG2;
        wen2_d  = 1'b0;
        fd_d    = prog_word(2'd2, empty_q, full_q);
      end
      PROG2: begin
        state_d = PROG3;
        wen2_d  = 1'b0;
        fd_d    = prog_word(2'd3, empty_q, full_q);
      end
      PROG3: state_d = SETTLE;
      SETTLE: begin
        state_d = RUN;
        done_d  = 1'b1;
      end
      RUN: begin
        if (CFG_START) begin
          state_d = RST_FIFO;
          rcnt_d  = RCW'(RST_CYCLES);
          rs_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          done_d = 1'b1;
          if (|gnt) begin
            wen1_d = 1'b0;
            ack_d  = gnt;
            fd_d   = gnt[1] ? bus.D1 : bus.D0;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = RST_FIFO;
        rcnt_d  = RCW'(RST_CYCLES);
        rs_d    = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RS_N) begin
      state_q <= RST_FIFO;
      rcnt_q  <= RCW'(RST_CYCLES);
      empty_q <= '0;
      full_q  <= '0;
      rs_q    <= 1'b1;
      wen1_q  <= 1'b1;
      wen2_q  <= 1'b1;
      fd_q    <= '0;
      ack_q   <= 2'b00;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      rs_q    <= rs_d;
      wen1_q  <= wen1_d;
      wen2_q  <= wen2_d;
      fd_q    <= fd_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.FIFO_RS   = rs_q;
  assign bus.FIFO_WEN1 = wen1_q;
  assign bus.FIFO_WEN2 = wen2_q;
  assign bus.FIFO_D    = fd_q;
  assign bus.ACK0      = ack_q[0];
  assign bus.ACK1      = ack_q[1];
  assign CFG_DONE      = done_q;
  assign WR_COUNT      = cnt_q;
endmodule

// File: tb/tb_fifo_prog_wr_ctrl.sv
// Directed bench for fifo_prog_wr_ctrl: reset, offset programming, round-robin
// writes, full-flag stall, CFG_START reprogramming and reset mid-programming.
module tb_fifo_prog_wr_ctrl;
  logic        CLK;
  logic        RS_N;
  logic [8:0]  CFG_EMPTY_OFF, CFG_FULL_OFF;
  logic        CFG_START;
  logic        CFG_DONE;
  logic [15:0] WR_COUNT;
  int          total = 0;
  int          bad   = 0;
  int          exp_cnt;

  fifo_prog_wr_ctrl_if bus_if ();

  fifo_prog_wr_ctrl #(.RST_CYCLES(2), .CNT_W(16)) dut (
    .CLK           (CLK),
    .RS_N          (RS_N),
    .CFG_EMPTY_OFF (CFG_EMPTY_OFF),
    .CFG_FULL_OFF  (CFG_FULL_OFF),
    .CFG_START     (CFG_START),
    .bus           (bus_if),
    .CFG_DONE      (CFG_DONE),
    .WR_COUNT      (WR_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the first sample point after reset/CFG_START; ends in RUN (8th cycle).
  task automatic bringup(input logic [8:0] w0, input logic [8:0] w1,
                         input logic [8:0] w2, input logic [8:0] w3);
    logic [8:0] words [4];
    logic [7:0] rs_tab, wen2_tab, done_tab;
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    rs_tab   = 8'b0000_0011;
    wen2_tab = 8'b1100_0011;
    done_tab = 8'b1000_0000;
    for (int s = 0; s < 8; s++) begin
      if (s > 0) @(negedge CLK);
      chk($sformatf("bring_rs_s%0d", s),   32'(bus_if.FIFO_RS),   32'(rs_tab[s]));
      chk($sformatf("bring_wen2_s%0d", s), 32'(bus_if.FIFO_WEN2), 32'(wen2_tab[s]));
      chk($sformatf("bring_wen1_s%0d", s), 32'(bus_if.FIFO_WEN1), 32'd1);
      chk($sformatf("bring_done_s%0d", s), 32'(CFG_DONE),         32'(done_tab[s]));
      if (s >= 2 && s <= 5)
        chk($sformatf("bring_d_s%0d", s), 32'(bus_if.FIFO_D), 32'(words[s-2]));
    end
  endtask

  initial begin
    logic [8:0] vals [5];
    vals[0] = 9'h011; vals[1] = 9'h022; vals[2] = 9'h033; vals[3] = 9'h044; vals[4] = 9'h055;

    RS_N = 1'b0; CFG_START = 1'b0;
    CFG_EMPTY_OFF = 9'h105; CFG_FULL_OFF = 9'h0A3;
    bus_if.REQ0 = 1'b0; bus_if.REQ1 = 1'b0;
    bus_if.D0 = '0; bus_if.D1 = '0;
    bus_if.FIFO_FF = 1'b0; bus_if.FIFO_PAF = 1'b0;

    repeat (3) @(negedge CLK);
    chk("rst_rs",    32'(bus_if.FIFO_RS),   32'd1);
    chk("rst_wen1",  32'(bus_if.FIFO_WEN1), 32'd1);
    chk("rst_wen2",  32'(bus_if.FIFO_WEN2), 32'd1);
    chk("rst_d",     32'(bus_if.FIFO_D),    32'd0);
    chk("rst_ack0",  32'(bus_if.ACK0),      32'd0);
    chk("rst_ack1",  32'(bus_if.ACK1),      32'd0);
    chk("rst_done",  32'(CFG_DONE),         32'd0);
    chk("rst_count", 32'(WR_COUNT),         32'd0);
    RS_N = 1'b1;
    bringup(9'h005, 9'h001, 9'h0A3, 9'h000);

    // both requesters: alternate every cycle, ACK0 first
    bus_if.REQ0 = 1'b1; bus_if.REQ1 = 1'b1;
    bus_if.D0 = 9'h0AA; bus_if.D1 = 9'h155;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk($sformatf("rr_ack0_%0d", k),  32'(bus_if.ACK0),      32'((k % 2) == 0));
      chk($sformatf("rr_ack1_%0d", k),  32'(bus_if.ACK1),      32'((k % 2) == 1));
      chk($sformatf("rr_wen1_%0d", k),  32'(bus_if.FIFO_WEN1), 32'd0);
      chk($sformatf("rr_d_%0d", k),     32'(bus_if.FIFO_D),    (k % 2) ? 32'h155 : 32'h0AA);
      chk($sformatf("rr_count_%0d", k), 32'(WR_COUNT),         32'(k + 1));
    end
    bus_if.REQ0 = 1'b0; bus_if.REQ1 = 1'b0;
    @(negedge CLK);
    chk("idle_wen1",  32'(bus_if.FIFO_WEN1), 32'd1);
    chk("idle_ack0",  32'(bus_if.ACK0),      32'd0);
    chk("idle_ack1",  32'(bus_if.ACK1),      32'd0);
    chk("idle_dhold", 32'(bus_if.FIFO_D),    32'h155);
    chk("idle_count", 32'(WR_COUNT),         32'd6);

    // single requester: one word every 2 cycles, each word written once
    bus_if.REQ0 = 1'b1; bus_if.D0 = vals[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("one_ack_%0d", k),   32'(bus_if.ACK0),      32'd1);
      chk($sformatf("one_ack1_%0d", k),  32'(bus_if.ACK1),      32'd0);
      chk($sformatf("one_wen1_%0d", k),  32'(bus_if.FIFO_WEN1), 32'd0);
      chk($sformatf("one_d_%0d", k),     32'(bus_if.FIFO_D),    32'(vals[k]));
      chk($sformatf("one_count_%0d", k), 32'(WR_COUNT),         32'(7 + k));
      bus_if.D0 = vals[k+1];
      @(negedge CLK);
      chk($sformatf("gap_ack_%0d", k),   32'(bus_if.ACK0),      32'd0);
      chk($sformatf("gap_wen1_%0d", k),  32'(bus_if.FIFO_WEN1), 32'd1);
      chk($sformatf("gap_count_%0d", k), 32'(WR_COUNT),         32'(7 + k));
    end

    // full flag stalls the port
    bus_if.FIFO_FF = 1'b1; bus_if.D0 = 9'h1FF;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("ff_ack_%0d", k),   32'(bus_if.ACK0),      32'd0);
      chk($sformatf("ff_wen1_%0d", k),  32'(bus_if.FIFO_WEN1), 32'd1);
      chk($sformatf("ff_count_%0d", k), 32'(WR_COUNT),         32'd10);
    end
    bus_if.FIFO_FF = 1'b0; bus_if.FIFO_PAF = 1'b1;
    @(negedge CLK);
`ifdef FIFO_PROG_WR_CTRL_PAF_THROTTLE_EN
    chk("paf_ack",   32'(bus_if.ACK0),      32'd0);
    chk("paf_wen1",  32'(bus_if.FIFO_WEN1), 32'd1);
    chk("paf_count", 32'(WR_COUNT),         32'd10);
    exp_cnt = 10;
`else
    chk("paf_ack",   32'(bus_if.ACK0),      32'd1);
    chk("paf_wen1",  32'(bus_if.FIFO_WEN1), 32'd0);
    chk("paf_d",     32'(bus_if.FIFO_D),    32'h1FF);
    chk("paf_count", 32'(WR_COUNT),         32'd11);
    exp_cnt = 11;
`endif
    bus_if.REQ0 = 1'b0; bus_if.FIFO_PAF = 1'b0;
    @(negedge CLK);
    chk("post_ack",   32'(bus_if.ACK0),      32'd0);
    chk("post_wen1",  32'(bus_if.FIFO_WEN1), 32'd1);
    chk("post_count", 32'(WR_COUNT),         32'(exp_cnt));

    // CFG_START reprograms with the new full offset
    CFG_FULL_OFF = 9'h010; CFG_START = 1'b1;
    @(negedge CLK);
    CFG_START = 1'b0;
    chk("cs_count", 32'(WR_COUNT),         32'd0);
    chk("cs_done",  32'(CFG_DONE),         32'd0);
    chk("cs_ack0",  32'(bus_if.ACK0),      32'd0);
    chk("cs_wen1",  32'(bus_if.FIFO_WEN1), 32'd1);
    bringup(9'h005, 9'h001, 9'h010, 9'h000);

    // RS_N during PROG2 restarts the reset sequence
    CFG_START = 1'b1;
    @(negedge CLK);
    CFG_START = 1'b0;
    repeat (4) @(negedge CLK);
    chk("p2_wen2", 32'(bus_if.FIFO_WEN2), 32'd0);
    chk("p2_d",    32'(bus_if.FIFO_D),    32'h010);
    RS_N = 1'b0;
    @(negedge CLK);
    chk("p2rst_rs",   32'(bus_if.FIFO_RS),   32'd1);
    chk("p2rst_wen2", 32'(bus_if.FIFO_WEN2), 32'd1);
    chk("p2rst_d",    32'(bus_if.FIFO_D),    32'd0);
    chk("p2rst_done", 32'(CFG_DONE),         32'd0);
    RS_N = 1'b1;
    bringup(9'h005, 9'h001, 9'h010, 9'h000);

    // reset returns priority to requester 0
    bus_if.REQ0 = 1'b1; bus_if.REQ1 = 1'b1;
    bus_if.D0 = 9'h0C3; bus_if.D1 = 9'h13C;
    @(negedge CLK);
    chk("ptr_ack0", 32'(bus_if.ACK0),   32'd1);
    chk("ptr_ack1", 32'(bus_if.ACK1),   32'd0);
    chk("ptr_d",    32'(bus_if.FIFO_D), 32'h0C3);
    bus_if.REQ0 = 1'b0; bus_if.REQ1 = 1'b0;
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
